// File: rtl/seq_pkg.sv
// Shared definitions for the register-file sequencer: opcodes, instruction
// field positions and the FSM state type.
package seq_pkg;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_LDI = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_MOV = 4'd7;
    localparam logic [3:0] OP_OUT = 4'd8;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned OP_LSB   = 12;
    localparam int unsigned OP_W     = 4;
    localparam int unsigned RD_LSB   = 9;
    localparam int unsigned RA_LSB   = 6;
    localparam int unsigned RB_LSB   = 3;
    localparam int unsigned ADRS_W   = 3;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned IMM_W    = 9;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StExec,
        StWrite,
        StRetire
    } seq_state_t;

    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_OUT;
    endfunction

endpackage

// File: rtl/seq_alu.sv
// Combinational datapath: ALU operations, MOV/OUT pass-through and LDI
// immediate extension.
module seq_alu
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter bit          LDI_SIGNED = 1'b1
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [8:0]        imm9,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] imm_ext;

    always_comb begin
        imm_ext = {{(DATA_W-9){LDI_SIGNED & imm9[8]}}, imm9};
        result  = '0;
        case (op)
            OP_LDI:         result = imm_ext;
            OP_ADD:         result = a + b;
            OP_SUB:         result = a - b;
            OP_AND:         result = a & b;
            OP_OR:          result = a | b;
            OP_XOR:         result = a ^ b;
            OP_MOV, OP_OUT: result = a;
            default:        result = '0;
        endcase
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Single-issue instruction sequencer driving an 8-entry register file.
// All outputs are registered from the next state (Moore).
module regfile_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter bit          LDI_SIGNED = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [15:0]       instr,
    output logic              rf_enable,
    output logic              rf_wr_en,
    output logic [2:0]        rf_rd_adrs,
    output logic [2:0]        rf_ra_adrs,
    output logic [2:0]        rf_rb_adrs,
    output logic [DATA_W-1:0] rf_data,
    input  logic [DATA_W-1:0] rf_ra_data,
    input  logic [DATA_W-1:0] rf_rb_data,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              done,
    output logic              illegal
);

    seq_state_t state_q, state_d;

    logic [INSTR_W-1:0] instr_q;
    logic [INSTR_W-1:0] cur_instr;
    logic [OP_W-1:0]    cur_op;
    logic [ADRS_W-1:0]  cur_rd, cur_ra, cur_rb;
    logic [IMM_W-1:0]   cur_imm;
    logic [DATA_W-1:0]  alu_result;

    logic              ready_q, enable_q, wr_en_q, done_q, illegal_q, result_valid_q;
    logic [2:0]        rd_adrs_q, ra_adrs_q, rb_adrs_q;
    logic [DATA_W-1:0] data_q, result_data_q;

    // In IDLE the live instruction is decoded so LDI/NOP can branch on the accept edge.
    assign cur_instr = (state_q == StIdle) ? instr : instr_q;
    assign cur_op    = cur_instr[OP_LSB +: OP_W];
    assign cur_rd    = cur_instr[RD_LSB +: ADRS_W];
    assign cur_ra    = cur_instr[RA_LSB +: ADRS_W];
    assign cur_rb    = cur_instr[RB_LSB +: ADRS_W];
    assign cur_imm   = cur_instr[IMM_LSB +: IMM_W];

    seq_alu #(
        .DATA_W     (DATA_W),
        .LDI_SIGNED (LDI_SIGNED)
    ) u_alu (
        .op     (cur_op),
        .a      (rf_ra_data),
        .b      (rf_rb_data),
        .imm9   (cur_imm),
        .result (alu_result)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (instr_valid && ready_q) begin
                    if (cur_op == OP_NOP || !op_is_legal(cur_op)) begin
                        state_d = StRetire;
                    end else if (cur_op == OP_LDI) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:   state_d = StExec;
            StExec:   state_d = (cur_op == OP_OUT) ? StRetire : StWrite;
            StWrite:  state_d = StRetire;
            StRetire: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q        <= StIdle;
            instr_q        <= '0;
            ready_q        <= 1'b1;
            enable_q       <= 1'b0;
            wr_en_q        <= 1'b0;
            done_q         <= 1'b0;
            illegal_q      <= 1'b0;
            result_valid_q <= 1'b0;
            rd_adrs_q      <= '0;
            ra_adrs_q      <= '0;
            rb_adrs_q      <= '0;
            data_q         <= '0;
            result_data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == StIdle && instr_valid && ready_q) begin
                instr_q <= instr;
            end
            ready_q        <= (state_d == StIdle);
            enable_q       <= (state_d == StRead) || (state_d == StWrite);
            wr_en_q        <= (state_d == StWrite);
            done_q         <= (state_d == StRetire);
            illegal_q      <= (state_d == StRetire) && !op_is_legal(cur_op);
            result_valid_q <= (state_q == StExec) && (cur_op == OP_OUT);
            if (state_q == StExec && cur_op == OP_OUT) begin
                result_data_q <= rf_ra_data;
            end
            if (state_d == StRead) begin
                ra_adrs_q <= cur_ra;
                rb_adrs_q <= cur_rb;
            end
            // Covers both EXEC->WRITE (ALU result) and IDLE->WRITE (LDI immediate).
            if (state_d == StWrite) begin
                rd_adrs_q <= cur_rd;
                data_q    <= alu_result;
            end
        end
    end

    assign instr_ready  = ready_q;
    assign rf_enable    = enable_q;
    assign rf_wr_en     = wr_en_q;
    assign rf_rd_adrs   = rd_adrs_q;
    assign rf_ra_adrs   = ra_adrs_q;
    assign rf_rb_adrs   = rb_adrs_q;
    assign rf_data      = data_q;
    assign result_valid = result_valid_q;
    assign result_data  = result_data_q;
    assign done         = done_q;
    assign illegal      = illegal_q;

endmodule
